// File: rtl/wr_decoder_queue.sv
// wr_decoder_queue: register-file write-port front end.
// Buffers up to DEPTH pending writes in a circular queue and drains one per
// cycle into a registered one-hot write enable plus matching address/data.
// A per-register pending mask covers every queued entry and the live output
// stage, for hazard detection.
//
// Optional feature macro: WR_DECODER_ZERO_REG_EN
//   defined   - writes to register 2**ADDR_W-1 (hard-wired zero register) are
//               handshaken but never enqueued.
//   undefined - that address behaves like any other register.

module wr_decoder_queue #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic [(2**ADDR_W)-1:0]   we,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [(2**ADDR_W)-1:0]   pending
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage, indexed by head/tail.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              push_hs;
    logic              push_en;
    logic              pop_en;
    logic [PTR_W-1:0]  offset;

    // No pass-through when full: a pop on the same edge does not free a slot
    // early, so in_ready depends only on the registered count.
    assign in_ready = !reset && (count < CNT_W'(DEPTH));
    assign push_hs  = in_valid && in_ready;

`ifdef WR_DECODER_ZERO_REG_EN
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '1;
    // Writes to the zero register are accepted and silently discarded.
    assign push_en = push_hs && (in_addr != ZERO_ADDR);
`else
    assign push_en = push_hs;
`endif

    // Pop uses the pre-edge count, so a push into an empty queue is not
    // popped on the same edge.
    assign pop_en = (count != '0) && drain_en;

    // Queue payload write at the tail.
    // NOTE: storage has no reset; validity is tracked by head/count, so stale
    // contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push_en) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end
    end

    // Head/tail pointers and occupancy count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_en) begin
                tail <= tail + 1'b1;
            end
            if (pop_en) begin
                head <= head + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output stage: one-cycle one-hot enable per pop, zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we      <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (pop_en) begin
            we      <= NREG'(1) << addr_mem[head];
            wr_addr <= addr_mem[head];
            wr_data <= data_mem[head];
        end else begin
            we      <= '0;
        end
    end

    // Pending mask: live output stage plus every valid queued entry.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pending = we;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - head;
            if ({1'b0, offset} < count) begin
                pending = pending | (NREG'(1) << addr_mem[i]);
            end
        end
    end

endmodule

// File: tb/tb_wr_decoder_queue.sv
// Self-checking bench for wr_decoder_queue: directed vector table, directed
// corner sequences (streaming, reset mid-operation, zero register) and a
// randomized run, all checked against a queue-based reference model.

module tb_wr_decoder_queue;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;
    localparam int NREG   = 2**ADDR_W;

`ifdef WR_DECODER_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              drain_en;
    logic [NREG-1:0]   we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   pending;

    wr_decoder_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .drain_en (drain_en),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain FIFO of pending writes plus the expected
    // output-stage contents.
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } entry_t;

    entry_t            q[$];
    logic [NREG-1:0]   exp_we   = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;

    function automatic bit model_accepts(input logic [ADDR_W-1:0] a);
        return !(ZERO_EN && (a == ADDR_W'(NREG - 1)));
    endfunction

    function automatic logic [NREG-1:0] model_pending();
        logic [NREG-1:0] m;
        m = exp_we;
        foreach (q[i]) m[q[i].a] = 1'b1;
        return m;
    endfunction

    // Advance one clock edge with the currently driven inputs and compare.
    task automatic tick();
        bit     pop;
        bit     push;
        entry_t e;
        entry_t h;
        pop  = (q.size() > 0) && drain_en;
        push = in_valid && (q.size() < DEPTH) && model_accepts(in_addr);
        e.a  = in_addr;
        e.d  = in_data;
        if (pop) begin
            h        = q.pop_front();
            exp_we   = '0;
            exp_we[h.a] = 1'b1;
            exp_addr = h.a;
            exp_data = h.d;
        end else begin
            exp_we = '0;
        end
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        check("we", we, exp_we);
        check("pending", pending, model_pending());
        check("in_ready", in_ready, q.size() < DEPTH);
        check("we_onehot0", $onehot0(we), 1);
        if (exp_we != '0) begin
            check("wr_addr", wr_addr, exp_addr);
            check("wr_data", wr_data, exp_data);
        end
    endtask

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              dr;
        logic [NREG-1:0]   ewe;
        logic [NREG-1:0]   epend;
        logic              erdy;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] edata;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Single write, then fill/stall with a held third request.
        tbl[0] = '{1'b1, 5'd3, 64'hAB, 1'b1, 32'h0,  32'h8,  1'b1, 5'd0, 64'h0};
        tbl[1] = '{1'b0, 5'd0, 64'h0,  1'b1, 32'h8,  32'h8,  1'b1, 5'd3, 64'hAB};
        tbl[2] = '{1'b0, 5'd0, 64'h0,  1'b1, 32'h0,  32'h0,  1'b1, 5'd0, 64'h0};
        tbl[3] = '{1'b1, 5'd1, 64'h11, 1'b0, 32'h0,  32'h2,  1'b1, 5'd0, 64'h0};
        tbl[4] = '{1'b1, 5'd2, 64'h22, 1'b0, 32'h0,  32'h6,  1'b0, 5'd0, 64'h0};
        tbl[5] = '{1'b1, 5'd5, 64'h55, 1'b0, 32'h0,  32'h6,  1'b0, 5'd0, 64'h0};
        tbl[6] = '{1'b1, 5'd5, 64'h55, 1'b1, 32'h2,  32'h6,  1'b1, 5'd1, 64'h11};
        tbl[7] = '{1'b1, 5'd5, 64'h55, 1'b1, 32'h4,  32'h24, 1'b1, 5'd2, 64'h22};
        tbl[8] = '{1'b0, 5'd0, 64'h0,  1'b1, 32'h20, 32'h20, 1'b1, 5'd5, 64'h55};
        tbl[9] = '{1'b0, 5'd0, 64'h0,  1'b1, 32'h0,  32'h0,  1'b1, 5'd0, 64'h0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", we, 0);
        check("rst_pending", pending, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].v;
            in_addr  = tbl[i].a;
            in_data  = tbl[i].d;
            drain_en = tbl[i].dr;
            tick();
            check($sformatf("tbl%0d_we", i), we, tbl[i].ewe);
            check($sformatf("tbl%0d_pending", i), pending, tbl[i].epend);
            check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].erdy);
            if (tbl[i].ewe != '0) begin
                check($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].eaddr);
                check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].edata);
            end
        end

        // Streaming: back-to-back addr 0..7 with drain_en high.
        drain_en = 1'b1;
        for (int a = 0; a <= 8; a++) begin
            in_valid = (a < 8);
            in_addr  = ADDR_W'(a);
            in_data  = {$urandom, $urandom};
            tick();
            check("stream_in_ready", in_ready, 1);
            check("stream_we", we, (a > 0) ? (64'h1 << (a - 1)) : 64'h0);
        end
        in_valid = 1'b0;
        tick();

        // Randomized run with random drain_en; pointers wrap many times.
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_addr  = ADDR_W'($urandom);
            in_data  = {$urandom, $urandom};
            drain_en = $urandom_range(0, 1) == 1;
            tick();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        repeat (DEPTH + 2) tick();

        // Reset mid-operation: entry queued and we active.
        drain_en = 1'b0;
        in_valid = 1'b1;
        in_addr  = 5'd10; in_data = 64'hA0; tick();
        in_addr  = 5'd11; in_data = 64'hA1; tick();
        drain_en = 1'b1;
        in_addr  = 5'd12; in_data = 64'hA2; tick();
        in_addr  = 5'd13; in_data = 64'hA3; tick();
        check("mid_we_active", we != '0, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_in_ready", in_ready, 0);
        q.delete();
        exp_we   = '0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            tick();
            check("post_rst_no_stale", we, 0);
        end

        // Zero register handling.
        in_valid = 1'b1;
        in_addr  = 5'd31;
        in_data  = 64'h77;
        tick();
        check("zr_pending_after_push", pending, ZERO_EN ? 64'h0 : 64'h8000_0000);
        in_valid = 1'b0;
        tick();
        check("zr_we", we, ZERO_EN ? 64'h0 : 64'h8000_0000);
        tick();
        check("zr_we_end", we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
